// File: rtl/traffic_light_pkg.sv
// Shared types and encodings for the traffic light bus monitor.
package traffic_light_pkg;

    localparam int unsigned LIGHT_W = 3;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned ERR_W   = 3;

    // One-hot codes seen on the light bus
    localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b001;
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b100;

    // Reported phase; PH_NONE also means "not synchronised"
    typedef enum logic [PHASE_W-1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    localparam logic [ERR_W-1:0] ERR_NONE  = 3'd0;
    localparam logic [ERR_W-1:0] ERR_ENC   = 3'd1;
    localparam logic [ERR_W-1:0] ERR_SEQ   = 3'd2;
    localparam logic [ERR_W-1:0] ERR_SHORT = 3'd3;
    localparam logic [ERR_W-1:0] ERR_LONG  = 3'd4;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_TRACK = 2'd2
    } state_e;

    // Error flags; bit 0 is the encoding error
    typedef struct packed {
        logic long_dw;
        logic short_dw;
        logic seq;
        logic enc;
    } err_bits_t;

    // Map a bus sample to a phase; anything not one of the three codes is PH_NONE
    function automatic phase_e decode_light(input logic [LIGHT_W-1:0] code);
        phase_e ph;
        case (code)
            LIGHT_RED:    ph = PH_RED;
            LIGHT_GREEN:  ph = PH_GREEN;
            LIGHT_YELLOW: ph = PH_YELLOW;
            default:      ph = PH_NONE;
        endcase
        return ph;
    endfunction

    // True when from->to is one of RED->GREEN, GREEN->YELLOW, YELLOW->RED
    function automatic logic seq_legal(input phase_e from, input phase_e to);
        logic ok;
        case (from)
            PH_RED:    ok = (to == PH_GREEN);
            PH_GREEN:  ok = (to == PH_YELLOW);
            PH_YELLOW: ok = (to == PH_RED);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light bus plus monitor status outputs; the monitor is the slave side.
interface traffic_light_monitor_if #(
    parameter int unsigned DW = 16
);
    logic [2:0]    light;
    logic          err_clr;
    logic [1:0]    phase;
    logic          in_sync;
    logic [DW-1:0] dwell;
    logic          cycle_done;
    logic [DW-1:0] cycle_cnt;
    logic          err_pulse;
    logic [2:0]    err_code;
    logic [3:0]    err_sticky;

    modport master (
        output light, err_clr,
        input  phase, in_sync, dwell, cycle_done, cycle_cnt,
               err_pulse, err_code, err_sticky
    );

    modport slave (
        input  light, err_clr,
        output phase, in_sync, dwell, cycle_done, cycle_cnt,
               err_pulse, err_code, err_sticky
    );
endinterface

// File: rtl/tl_phase_timer.sv
// Saturating dwell counter with short/long compares against the selected phase's expected dwell.
module tl_phase_timer
    import traffic_light_pkg::*;
#(
    parameter int unsigned DW            = 16,
    parameter int unsigned RED_CYCLES    = 51,
    parameter int unsigned GREEN_CYCLES  = 31,
    parameter int unsigned YELLOW_CYCLES = 11,
    parameter int unsigned TOL           = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          restart_i,
    input  logic          advance_i,
    input  phase_e        sel_i,
    output logic [DW-1:0] dwell_o,
    output logic          short_c_o,
    output logic          long_c_o
);

    // One extra bit so X+TOL+1 never overflows
    localparam int unsigned EW = DW + 1;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [EW-1:0] exp_w, lo_w, hi1_w, dwell_w;

    // Next dwell: clear on bad code, 1 on a new phase, saturating increment otherwise
    always_comb begin
        dwell_d = dwell_q;
        if (clear_i) begin
            dwell_d = '0;
        end else if (restart_i) begin
            dwell_d = DW'(1);
        end else if (advance_i && (dwell_q != '1)) begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    // Dwell counter register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    // Bounds for the phase currently being timed
    always_comb begin
        case (sel_i)
            PH_RED:    exp_w = EW'(RED_CYCLES);
            PH_GREEN:  exp_w = EW'(GREEN_CYCLES);
            PH_YELLOW: exp_w = EW'(YELLOW_CYCLES);
            default:   exp_w = '0;
        endcase
        lo_w    = (exp_w > EW'(TOL)) ? (exp_w - EW'(TOL)) : '0;
        hi1_w   = exp_w + EW'(TOL) + EW'(1);
        dwell_w = {1'b0, dwell_q};
    end

    assign dwell_o   = dwell_q;
    // Ending dwell too short if the phase ends now
    assign short_c_o = (dwell_w < lo_w);
    // One more sample of the same phase reaches X+TOL+1
    assign long_c_o  = ((dwell_w + EW'(1)) == hi1_w);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot traffic light bus: phase tracking, timing, sequence and cycle count.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned RED_CYCLES    = 51,
    parameter int unsigned GREEN_CYCLES  = 31,
    parameter int unsigned YELLOW_CYCLES = 11,
    parameter int unsigned TOL           = 0,
    parameter int unsigned DW            = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    traffic_light_monitor_if.slave  mon
);

    state_e        state_q;
    phase_e        phase_q;
    logic          in_sync_q;
    logic          cycle_done_q;
    logic [DW-1:0] cycle_cnt_q;
    logic          err_pulse_q;
    logic [2:0]    err_code_q;
    err_bits_t     sticky_q;
    logic          enc_hold_q;
    logic          long_fired_q;
    logic          green_ok_q;
    logic          yellow_ok_q;

    phase_e        cur_ph;
    logic          code_ok, changed, seq_ok;
    logic          cycle_hit;
    logic          t_clear, t_restart, t_advance;
    logic          t_short, t_long;
    logic [DW-1:0] dwell;
    err_bits_t     err_bits;
    logic [2:0]    err_code_c;

    // Decode the sample and work out which events it produces this edge
    always_comb begin
        cur_ph    = decode_light(mon.light);
        code_ok   = (cur_ph != PH_NONE);
        changed   = code_ok && (state_q != ST_SYNC) && (cur_ph != phase_q);
        seq_ok    = seq_legal(phase_q, cur_ph);
        t_clear   = !code_ok;
        t_restart = code_ok && ((state_q == ST_SYNC) || changed);
        t_advance = code_ok && !t_restart;

        err_bits          = '0;
        // A run of bad codes reports once; a legal sample re-arms it
        err_bits.enc      = !code_ok && !enc_hold_q;
        err_bits.seq      = changed && !seq_ok;
        // A phase that already overran is not timed again when it ends
        err_bits.short_dw = changed && (state_q == ST_TRACK) && !long_fired_q && t_short;
        err_bits.long_dw  = code_ok && !changed && (state_q == ST_TRACK) && !long_fired_q && t_long;

        err_code_c = ERR_NONE;
        if (err_bits.enc) begin
            err_code_c = ERR_ENC;
        end else if (err_bits.seq) begin
            err_code_c = ERR_SEQ;
        end else if (err_bits.short_dw) begin
            err_code_c = ERR_SHORT;
        end else if (err_bits.long_dw) begin
            err_code_c = ERR_LONG;
        end

        // Only cycles whose GREEN and YELLOW were both entered legally while tracking count
        cycle_hit = changed && (state_q == ST_TRACK) && (phase_q == PH_YELLOW) &&
                    (cur_ph == PH_RED) && yellow_ok_q;
    end

    tl_phase_timer #(
        .DW            (DW),
        .RED_CYCLES    (RED_CYCLES),
        .GREEN_CYCLES  (GREEN_CYCLES),
        .YELLOW_CYCLES (YELLOW_CYCLES),
        .TOL           (TOL)
    ) u_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (t_clear),
        .restart_i (t_restart),
        .advance_i (t_advance),
        .sel_i     (phase_q),
        .dwell_o   (dwell),
        .short_c_o (t_short),
        .long_c_o  (t_long)
    );

    // Monitor FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            phase_q      <= PH_NONE;
            in_sync_q    <= 1'b0;
            cycle_done_q <= 1'b0;
            cycle_cnt_q  <= '0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            sticky_q     <= '0;
            enc_hold_q   <= 1'b0;
            long_fired_q <= 1'b0;
            green_ok_q   <= 1'b0;
            yellow_ok_q  <= 1'b0;
        end else begin
            cycle_done_q <= cycle_hit;
            if (cycle_hit) begin
                cycle_cnt_q <= cycle_cnt_q + DW'(1);
            end
            err_pulse_q <= |err_bits;
            err_code_q  <= err_code_c;
            // A clear on the same edge as a new error keeps only the new error's bits
            sticky_q    <= mon.err_clr ? err_bits : err_bits_t'(sticky_q | err_bits);

            if (!code_ok) begin
                state_q      <= ST_SYNC;
                phase_q      <= PH_NONE;
                in_sync_q    <= 1'b0;
                enc_hold_q   <= 1'b1;
                long_fired_q <= 1'b0;
                green_ok_q   <= 1'b0;
                yellow_ok_q  <= 1'b0;
            end else begin
                enc_hold_q <= 1'b0;
                in_sync_q  <= 1'b1;
                case (state_q)
                    ST_SYNC: begin
                        phase_q      <= cur_ph;
                        long_fired_q <= 1'b0;
                        state_q      <= ST_ALIGN;
                    end
                    ST_ALIGN: begin
                        // First phase was seen part-way through; its cycle is not counted
                        if (changed) begin
                            phase_q      <= cur_ph;
                            long_fired_q <= 1'b0;
                            state_q      <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (changed) begin
                            phase_q      <= cur_ph;
                            long_fired_q <= 1'b0;
                            green_ok_q   <= seq_ok && (cur_ph == PH_GREEN);
                            yellow_ok_q  <= seq_ok && (cur_ph == PH_YELLOW) && green_ok_q;
                        end else if (err_bits.long_dw) begin
                            long_fired_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_SYNC;
                        phase_q <= PH_NONE;
                    end
                endcase
            end
        end
    end

    assign mon.phase      = phase_q;
    assign mon.in_sync    = in_sync_q;
    assign mon.dwell      = dwell;
    assign mon.cycle_done = cycle_done_q;
    assign mon.cycle_cnt  = cycle_cnt_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_code   = err_code_q;
    assign mon.err_sticky = sticky_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboarded bench for traffic_light_monitor: directed scenarios plus a randomised tail.
module tb_traffic_light_monitor;

    localparam int R_X = 51;
    localparam int G_X = 31;
    localparam int Y_X = 11;
    localparam int TOLV = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;

    traffic_light_monitor_if #(.DW(16)) bus ();

    traffic_light_monitor #(
        .RED_CYCLES    (R_X),
        .GREEN_CYCLES  (G_X),
        .YELLOW_CYCLES (Y_X),
        .TOL           (TOLV),
        .DW            (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ph;
        int sync;
        int dw;
        int done;
        int cnt;
        int pulse;
        int code;
        int sticky;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_mode = 0;      // 0 unsynced, 1 first phase, 2 tracking
    int m_ph = 0;
    int m_dw = 0;
    int m_long = 0;
    int m_hold = 0;
    int m_chain = 0;     // legal tracked steps into the current cycle
    int m_cnt = 0;
    int m_sticky = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dec(input logic [2:0] l);
        if (l == 3'b001) return 1;
        if (l == 3'b100) return 2;
        if (l == 3'b010) return 3;
        return 0;
    endfunction

    function automatic int target(input int ph);
        if (ph == 1) return R_X;
        if (ph == 2) return G_X;
        return Y_X;
    endfunction

    // Advance the model by one sample and produce the outputs expected after the edge
    task automatic model(input logic [2:0] l, input logic clr, input logic rst, output exp_t e);
        int p;
        int bits;
        int done;
        bits = 0;
        done = 0;
        if (rst) begin
            m_mode = 0; m_ph = 0; m_dw = 0; m_long = 0; m_hold = 0;
            m_chain = 0; m_cnt = 0; m_sticky = 0;
        end else begin
            p = dec(l);
            if (p == 0) begin
                if (m_hold == 0) bits = bits | 1;
                m_hold = 1; m_mode = 0; m_ph = 0; m_dw = 0; m_chain = 0; m_long = 0;
            end else begin
                m_hold = 0;
                if (m_mode == 0) begin
                    m_mode = 1; m_ph = p; m_dw = 1; m_long = 0;
                end else if (p != m_ph) begin
                    if (p != (m_ph % 3) + 1) bits = bits | 2;
                    if (m_mode == 2) begin
                        if (m_long == 0 && m_dw < target(m_ph) - TOLV) bits = bits | 4;
                        if ((bits & 2) != 0) m_chain = 0;
                        else if (p == 2) m_chain = 1;
                        else if (p == 3) m_chain = (m_chain == 1) ? 2 : 0;
                        else begin
                            done = (m_chain == 2) ? 1 : 0;
                            m_chain = 0;
                        end
                    end
                    m_mode = 2; m_ph = p; m_dw = 1; m_long = 0;
                end else begin
                    if (m_dw < 65535) m_dw++;
                    if (m_mode == 2 && m_long == 0 && m_dw == target(m_ph) + TOLV + 1) begin
                        bits = bits | 8;
                        m_long = 1;
                    end
                end
            end
            m_sticky = clr ? bits : (m_sticky | bits);
            m_cnt = (m_cnt + done) & 16'hFFFF;
        end
        e.ph     = m_ph;
        e.sync   = (m_mode != 0) ? 1 : 0;
        e.dw     = m_dw;
        e.done   = done;
        e.cnt    = m_cnt;
        e.pulse  = (bits != 0) ? 1 : 0;
        e.code   = (bits & 1) ? 1 : (bits & 2) ? 2 : (bits & 4) ? 3 : (bits & 8) ? 4 : 0;
        e.sticky = m_sticky;
    endtask

    // Drive one sample, queue its expectation, then compare after the edge
    task automatic step(input logic [2:0] l, input logic clr, input logic rst);
        exp_t e;
        exp_t x;
        bus.light   = l;
        bus.err_clr = clr;
        reset       = rst;
        model(l, clr, rst, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk("phase",      32'(bus.phase),      32'(x.ph));
            chk("in_sync",    32'(bus.in_sync),    32'(x.sync));
            chk("dwell",      32'(bus.dwell),      32'(x.dw));
            chk("cycle_done", 32'(bus.cycle_done), 32'(x.done));
            chk("cycle_cnt",  32'(bus.cycle_cnt),  32'(x.cnt));
            chk("err_pulse",  32'(bus.err_pulse),  32'(x.pulse));
            chk("err_code",   32'(bus.err_code),   32'(x.code));
            chk("err_sticky", 32'(bus.err_sticky), 32'(x.sticky));
        end
    endtask

    task automatic run(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] cur;
        int len;
        int sel;
        bus.light   = 3'b001;
        bus.err_clr = 1'b0;
        #2;

        // Reset: everything zero
        step(3'b001, 1'b0, 1'b1);
        step(3'b001, 1'b0, 1'b1);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_sticky", 32'(bus.err_sticky), 32'd0);

        // Two clean cycles; the first one starts part-way and is not counted
        step(3'b001, 1'b0, 1'b0);
        chk("t1_first_sync", 32'(bus.in_sync), 32'd1);
        run(3'b001, 50);
        run(3'b100, G_X); run(3'b010, Y_X);
        run(3'b001, 1);
        chk("t1_first_done", 32'(bus.cycle_done), 32'd0);
        run(3'b001, 50);
        run(3'b100, G_X); run(3'b010, Y_X);
        run(3'b001, 1);
        chk("t1_done", 32'(bus.cycle_done), 32'd1);
        chk("t1_cnt", 32'(bus.cycle_cnt), 32'd1);

        // RED straight to YELLOW
        run(3'b001, 50);
        run(3'b010, 1);
        chk("t2_code", 32'(bus.err_code), 32'd2);
        chk("t2_sticky", 32'(bus.err_sticky), 32'b0010);
        chk("t2_phase", 32'(bus.phase), 32'd3);
        run(3'b010, Y_X - 1);
        run(3'b001, 1);
        chk("t2_no_count", 32'(bus.cycle_done), 32'd0);
        step(3'b001, 1'b1, 1'b0);
        run(3'b001, 49);

        // Short GREEN
        run(3'b100, 30);
        run(3'b010, 1);
        chk("t3_code", 32'(bus.err_code), 32'd3);
        chk("t3_sticky2", 32'(bus.err_sticky[2]), 32'd1);
        run(3'b010, Y_X - 1);
        run(3'b001, 1);
        step(3'b001, 1'b1, 1'b0);
        run(3'b001, 49);

        // Long GREEN fires once at dwell 32, nothing at the following change
        run(3'b100, 32);
        chk("t4_code", 32'(bus.err_code), 32'd4);
        chk("t4_dwell", 32'(bus.dwell), 32'd32);
        run(3'b100, 8);
        run(3'b010, 1);
        chk("t4_no_err", 32'(bus.err_pulse), 32'd0);
        run(3'b010, Y_X - 1);

        // Illegal code run, then resync
        run(3'b011, 1);
        chk("t5_code", 32'(bus.err_code), 32'd1);
        run(3'b011, 2);
        chk("t5_no_repulse", 32'(bus.err_pulse), 32'd0);
        chk("t5_phase", 32'(bus.phase), 32'd0);
        chk("t5_sync", 32'(bus.in_sync), 32'd0);
        run(3'b001, 1);
        chk("t5_rephase", 32'(bus.phase), 32'd1);
        chk("t5_resync", 32'(bus.in_sync), 32'd1);
        chk("t5_dwell", 32'(bus.dwell), 32'd1);

        // Reset mid-GREEN, then clear colliding with a sequence error
        run(3'b001, 50);
        run(3'b100, 15);
        chk("t6_dwell15", 32'(bus.dwell), 32'd15);
        step(3'b100, 1'b0, 1'b1);
        chk("t6_rst_dwell", 32'(bus.dwell), 32'd0);
        chk("t6_rst_cnt", 32'(bus.cycle_cnt), 32'd0);
        chk("t6_rst_sync", 32'(bus.in_sync), 32'd0);
        run(3'b000, 1);
        chk("t6_enc_sticky", 32'(bus.err_sticky), 32'b0001);
        run(3'b001, 3);
        step(3'b010, 1'b1, 1'b0);
        chk("t6_clr_sticky", 32'(bus.err_sticky), 32'b0010);

        // Randomised tail, mostly near-legal traffic
        cur = 3'b010;
        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) begin
                cur = (cur == 3'b001) ? 3'b100 : (cur == 3'b100) ? 3'b010 : 3'b001;
            end else if (sel < 9) begin
                sel = $urandom_range(0, 2);
                cur = (sel == 0) ? 3'b001 : (sel == 1) ? 3'b100 : 3'b010;
            end else begin
                cur = 3'($urandom_range(0, 7));
            end
            if (dec(cur) != 0) len = target(dec(cur)) + $urandom_range(0, 4) - 2;
            else len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                step(cur, ($urandom_range(0, 15) == 0), 1'b0);
            end
            if (r == 20) step(cur, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
